// File: rtl/seq_tx_pkg.sv
// seq_tx_pkg: shared state encoding and len-field width for the serial pattern transmitter
package seq_tx_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE     = 2'd0;
    localparam state_t SHIFT    = 2'd1;
    localparam state_t GAP_WAIT = 2'd2;
    localparam state_t DONE     = 2'd3;
    localparam int WIDTH_DEF = 8;
    // len must represent 0..WIDTH inclusive
    function automatic int len_bits(input int w);
        return $clog2(w) + 1;
    endfunction
    localparam int LEN_W = len_bits(WIDTH_DEF);
endpackage

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: request/serial-out bundle
//   master drives start, pattern, len, reps; slave drives x, valid, busy, done
interface seq_pattern_tx_if import seq_tx_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
);
    logic                       start;
    logic [WIDTH-1:0]           pattern;
    logic [len_bits(WIDTH)-1:0] len;
    logic [REP_W-1:0]           reps;
    logic                       x;
    logic                       valid;
    logic                       busy;
    logic                       done;
    modport master (output start, pattern, len, reps, input x, valid, busy, done);
    modport slave  (input start, pattern, len, reps, output x, valid, busy, done);
endinterface

// File: rtl/seq_bit_sel.sv
// seq_bit_sel: pattern shadow register with down-counting bit index
//   load: latch pattern/len, idx=len-1; reload: idx=len-1 from shadow len; advance: idx-1
//   cur_bit = shadow[idx], idx_zero = (idx == 0)
module seq_bit_sel import seq_tx_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       advance,
    input  logic                       reload,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [len_bits(WIDTH)-1:0] len,
    output logic                       cur_bit,
    output logic                       idx_zero
);
    localparam int IW = $clog2(WIDTH);
    localparam int LW = len_bits(WIDTH);
    logic [WIDTH-1:0] shadow;
    logic [LW-1:0]    len_q;
    logic [IW-1:0]    idx;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            len_q  <= '0;
            idx    <= '0;
        end else if (load) begin
            shadow <= pattern;
            len_q  <= len;
            idx    <= IW'(len - 1'b1);
        end else if (reload) begin
            idx <= IW'(len_q - 1'b1);
        end else if (advance) begin
            idx <= idx - 1'b1;
        end
    end
    assign cur_bit  = shadow[idx];
    assign idx_zero = (idx == '0);
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial pattern transmitter with repeat count and idle gap
//   clk, rst (async active-low); bus: start/pattern/len/reps in, x/valid/busy/done out
module seq_pattern_tx import seq_tx_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4,
    parameter int GAP   = 1
) (
    input logic              clk,
    input logic              rst,
    seq_pattern_tx_if.slave  bus
);
    localparam int LW = len_bits(WIDTH);
    localparam int GW = $clog2(GAP + 2);
    state_t           state, nxt;
    logic [REP_W-1:0] pcnt;
    logic [GW-1:0]    gcnt;
    logic [LW-1:0]    len_sat;
    logic             ready, accept, adv, rel, cur_bit, idx_zero;
    assign len_sat = (bus.len > LW'(WIDTH)) ? LW'(WIDTH) : bus.len;
    assign ready   = (state == IDLE) || (state == DONE);
    assign accept  = ready && bus.start;
    assign adv     = (state == SHIFT) && !idx_zero;
    assign rel     = (state == SHIFT) && idx_zero && (pcnt != '0);
    always_comb begin
        nxt = accept               ? ((len_sat == '0) ? DONE : SHIFT)
            : ready                ? IDLE
            : (state == GAP_WAIT)  ? ((gcnt == '0) ? SHIFT : GAP_WAIT)
            : !idx_zero            ? SHIFT
            : (pcnt == '0)         ? DONE
            : (GAP > 0)            ? GAP_WAIT : SHIFT;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pcnt  <= '0;
            gcnt  <= '0;
        end else begin
            state <= nxt;
            if (accept)
                pcnt <= bus.reps;
            else if (rel)
                pcnt <= pcnt - 1'b1;
            // gap counter is armed on the SHIFT->GAP_WAIT transition and runs down to 0
            if (state == SHIFT && nxt == GAP_WAIT)
                gcnt <= GW'(GAP - 1);
            else if (state == GAP_WAIT)
                gcnt <= gcnt - 1'b1;
        end
    end
    seq_bit_sel #(.WIDTH(WIDTH)) u_bit_sel (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .advance  (adv),
        .reload   (rel),
        .pattern  (bus.pattern),
        .len      (len_sat),
        .cur_bit  (cur_bit),
        .idx_zero (idx_zero)
    );
    assign bus.x     = (state == SHIFT) && cur_bit;
    assign bus.valid = (state == SHIFT);
    assign bus.busy  = (state == SHIFT) || (state == GAP_WAIT);
    assign bus.done  = (state == DONE);
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: randomized self-checking bench against a cycle-list reference model
module tb_seq_pattern_tx;
    localparam int W   = 8;
    localparam int RW  = 4;
    localparam int GAP = 1;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int passed = 0;
    int total  = 0;
    logic [3:0] exp_q[$];
    logic       obs_bits[$];
    seq_pattern_tx_if #(.WIDTH(W), .REP_W(RW)) bus ();
    seq_pattern_tx #(.WIDTH(W), .REP_W(RW), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;

    // expected per-cycle {x,valid,busy,done} after start: passes separated by GAP idle cycles, then done
    task automatic model(input logic [W-1:0] p, input int l, input int r);
        int n;
        n = (l > W) ? W : l;
        if (n > 0)
            for (int k = 0; k <= r; k++) begin
                for (int i = n - 1; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
                if (k < r) repeat (GAP) exp_q.push_back(4'b0010);
            end
        exp_q.push_back(4'b0001);
    endtask

    task automatic kick(input logic [W-1:0] p, input logic [3:0] l, input logic [RW-1:0] r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.pattern = p;
        bus.len = l;
        bus.reps = r;
    endtask

    task automatic run_check(input string name, input bit disturb, input int b2b_at,
                             input logic [W-1:0] p2, input logic [3:0] l2, input logic [RW-1:0] r2);
        logic [3:0] got;
        obs_bits.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            got = {bus.x, bus.valid, bus.busy, bus.done};
            total++;
            if (got !== exp_q[i])
                $display("FAIL %s cyc%0d {x,valid,busy,done} got=%b exp=%b", name, i + 1, got, exp_q[i]);
            else
                passed++;
            if (bus.valid) obs_bits.push_back(bus.x);
            if (i == b2b_at) begin
                bus.start = 1'b1;
                bus.pattern = p2;
                bus.len = l2;
                bus.reps = r2;
            end else if (disturb && exp_q[i][1]) begin
                bus.start = 1'($urandom);
                bus.pattern = W'($urandom);
                bus.len = 4'($urandom);
                bus.reps = RW'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({bus.x, bus.valid, bus.busy, bus.done} !== 4'b0000)
            $display("FAIL reset outputs got=%b exp=0000", {bus.x, bus.valid, bus.busy, bus.done});
        else
            passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.x, bus.valid, bus.busy, bus.done} !== 4'b0000)
            $display("FAIL idle_after_reset got=%b exp=0000", {bus.x, bus.valid, bus.busy, bus.done});
        else
            passed++;
    endtask

    task automatic test_basic();
        kick(8'b0000_0101, 4'd3, 4'd0);
        model(8'b0000_0101, 3, 0);
        exp_q.push_back(4'b0000);
        run_check("basic101", 1'b0, -1, '0, '0, '0);
    endtask

    task automatic test_reps_gap();
        int cnt, i;
        kick(8'b0000_0101, 4'd3, 4'd2);
        model(8'b0000_0101, 3, 2);
        exp_q.push_back(4'b0000);
        run_check("reps2_gap", 1'b0, -1, '0, '0, '0);
        cnt = 0;
        i = 0;
        while (i + 2 < obs_bits.size()) begin
            if (obs_bits[i] && !obs_bits[i+1] && obs_bits[i+2]) begin
                cnt++;
                i += 3;
            end else begin
                i++;
            end
        end
        total++;
        if (cnt !== 3) $display("FAIL det101_count got=%0d exp=3", cnt);
        else passed++;
    endtask

    task automatic test_len_edges();
        kick(8'hFF, 4'd0, 4'd3);
        model(8'hFF, 0, 3);
        exp_q.push_back(4'b0000);
        run_check("len0", 1'b0, -1, '0, '0, '0);
        kick(8'hA5, 4'd15, 4'd0);
        model(8'hA5, 15, 0);
        exp_q.push_back(4'b0000);
        run_check("len15_sat", 1'b0, -1, '0, '0, '0);
        kick(8'h02, 4'd2, 4'd1);
        model(8'h02, 2, 1);
        exp_q.push_back(4'b0000);
        run_check("len2_reps1", 1'b0, -1, '0, '0, '0);
    endtask

    task automatic test_ignore_midstart();
        kick(8'h96, 4'd8, 4'd1);
        model(8'h96, 8, 1);
        exp_q.push_back(4'b0000);
        run_check("midstart_ignored", 1'b1, -1, '0, '0, '0);
    endtask

    task automatic test_back_to_back();
        int at;
        kick(8'b0000_0101, 4'd3, 4'd0);
        model(8'b0000_0101, 3, 0);
        at = exp_q.size() - 1;
        model(8'b0000_1101, 4, 1);
        exp_q.push_back(4'b0000);
        run_check("back_to_back", 1'b0, at, 8'b0000_1101, 4'd4, 4'd1);
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        kick(8'b0000_0101, 4'd3, 4'd1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        got = {bus.x, bus.valid, bus.busy, bus.done};
        total++;
        if (got !== 4'b0110) $display("FAIL second_bit_pre_reset got=%b exp=0110", got);
        else passed++;
        #1 rst = 1'b0;
        #1 got = {bus.x, bus.valid, bus.busy, bus.done};
        total++;
        if (got !== 4'b0000) $display("FAIL async_reset_drop got=%b exp=0000", got);
        else passed++;
        repeat (3) begin
            @(negedge clk);
            got = {bus.x, bus.valid, bus.busy, bus.done};
            total++;
            if (got !== 4'b0000) $display("FAIL held_reset_no_done got=%b exp=0000", got);
            else passed++;
        end
        rst = 1'b1;
        @(negedge clk);
        got = {bus.x, bus.valid, bus.busy, bus.done};
        total++;
        if (got !== 4'b0000) $display("FAIL post_reset_no_done got=%b exp=0000", got);
        else passed++;
        kick(8'b0000_0101, 4'd3, 4'd0);
        model(8'b0000_0101, 3, 0);
        exp_q.push_back(4'b0000);
        run_check("fresh_after_reset", 1'b0, -1, '0, '0, '0);
    endtask

    task automatic test_random();
        logic [W-1:0]  p;
        logic [3:0]    l;
        logic [RW-1:0] r;
        for (int n = 0; n < 25; n++) begin
            p = W'($urandom);
            l = 4'($urandom_range(0, 15));
            r = RW'($urandom_range(0, 3));
            kick(p, l, r);
            model(p, int'(l), int'(r));
            exp_q.push_back(4'b0000);
            run_check("random", 1'($urandom), -1, '0, '0, '0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pattern = '0;
        bus.len = '0;
        bus.reps = '0;
        test_reset();
        test_basic();
        test_reps_gap();
        test_len_edges();
        test_ignore_midstart();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: loads an up-to-WIDTH-bit pattern and shifts it out MSB-first on a single-bit line, one bit per clock. It repeats the pattern a programmable number of times with a fixed idle gap between passes. It drives stimulus into the team's serial sequence detectors, and in-system it sources framed bit patterns such as "101" onto a serial link. Control is a Moore state machine with registered outputs and a start/busy/done handshake.

## Interface
- WIDTH, 8: maximum pattern length in bits (≥2).
- REP_W, 4: width of the repeat-count input.
- GAP, 1: idle cycles inserted between consecutive passes (0 allowed).
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- pattern  input  WIDTH  bits to send; bit len-1 goes first.
- len  input  $clog2(WIDTH)+1  number of valid bits (0..WIDTH; >WIDTH saturates to WIDTH).
- reps  input  REP_W  extra passes; total passes = reps+1.
- x  output  1  serial data, 0 when not valid.
- valid  output  1  x carries a pattern bit this cycle.
- busy  output  1  a transfer is in progress; start ignored.
- done  output  1  one-cycle pulse after the final bit of the final pass.

## Operation
- States: IDLE, SHIFT, GAP_WAIT, DONE (2-bit encoding).
- Reset (async, rst=0): state=IDLE; x=0, valid=0, busy=0, done=0; all internal counters and shadow registers cleared.
- IDLE or DONE with start=1:
  - Latch pattern, len (saturated) and reps into shadow registers.
  - If the latched len=0, go to DONE; no bits are sent.
  - Otherwise load the bit index with len-1 and the pass counter with reps, then go to SHIFT.
- Inputs are don't-care once latched. Changing pattern, len or reps during busy has no effect.
- SHIFT: x=shadow[idx], valid=1, busy=1.
  - If idx>0, decrement idx.
  - If idx=0 and passes remain, reload idx=len-1 and decrement the pass counter. Go to GAP_WAIT if GAP>0, otherwise stay in SHIFT (back-to-back).
  - If idx=0 and no passes remain, go to DONE.
- GAP_WAIT: x=0, valid=0, busy=1. Count GAP cycles, then go to SHIFT.
- DONE: done=1, busy=0, valid=0, for exactly one cycle. Next state is SHIFT (or DONE again if len=0) if start=1, else IDLE.
- IDLE: all outputs 0; stay until start.
- start while busy is ignored, with no queuing.
- All outputs are registered: decoded from the current state and datapath registers, never from inputs.

## Timing
- start sampled high at edge T → first bit valid in cycle T+1.
- Pass length: len cycles. Total bit cycles: (reps+1)·len.
- Total transfer cycles: (reps+1)·len + reps·GAP. done asserts in the cycle immediately after the last bit.
- len=0: done asserts in cycle T+1, valid never asserts.
- Back-to-back transfers: start held high in the DONE cycle gives the first bit of the next transfer in the following cycle. This is a one-cycle bubble, with done=1 in that bubble.
- Reset mid-transfer: outputs drop to 0 asynchronously. No done pulse is produced; the next start begins a fresh transfer.

## Structure
- Shared package seq_tx_pkg holds:
  - The state typedef (IDLE=2'd0, SHIFT=2'd1, GAP_WAIT=2'd2, DONE=2'd3).
  - The localparam for the len field width.
- One natural sub-module is seq_bit_sel: the pattern shadow register plus the down-counting bit index. It provides load/advance/reload controls and exposes the current bit and an idx_zero flag.
- The FSM, pass counter and gap counter stay in the top module.
- Target size is roughly 150–250 lines of RTL.

## Test plan
- pattern=8'b0000_0101, len=3, reps=0, start at T → x=1,0,1 with valid=1 in T+1..T+3; done=1 at T+4 only; busy=1 in T+1..T+3.
- Same pattern, reps=2, GAP=1 → bits 101,_,101,_,101 (valid=0 in the gap cycles); done at T+12; a downstream non-overlapping 101 detector pulses 3 times.
- reps=1, GAP=0 → x=1,0,1,1,0,1 contiguous in T+1..T+6; done at T+7.
- len=0 with start → done at T+1, valid never asserts. len=15 with WIDTH=8 → 8 bits sent.
- start pulsed mid-transfer and pattern changed mid-transfer → output stream unchanged. start held in the DONE cycle → new transfer's first bit in the next cycle.
- rst low during the 2nd bit → x/valid/busy go 0 immediately, no done; after release, start sends a full fresh pattern.
